// File: rtl/muldiv_if.sv
// Decoder/regfile-side bundle for the HI/LO multiply-divide unit.
// The unit itself connects through the slave modport; the E-stage side uses master.
interface muldiv_if #(parameter int DATA_W = 32);
    logic              op_mult;
    logic              op_multu;
    logic              op_div;
    logic              op_divu;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              mthi;
    logic              mtlo;
    logic [DATA_W-1:0] wdata;
    logic              flush;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              busy;
    logic              stall;

    modport master (
        output op_mult, op_multu, op_div, op_divu, src_a, src_b,
               mthi, mtlo, wdata, flush,
        input  hi, lo, busy, stall
    );

    modport slave (
        input  op_mult, op_multu, op_div, op_divu, src_a, src_b,
               mthi, mtlo, wdata, flush,
        output hi, lo, busy, stall
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply-divide unit: single-cycle multiply, 32-step restoring divide,
// MTHI/MTLO writes and pipeline stall generation.
module muldiv_ctrl #(
    parameter int DATA_W = 32
) (
    input  logic   clk,
    input  logic   resetn,
    muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sgn_q, sgn_d;

    logic                start_any, accept, start_sgn, take;
    logic [DATA_W:0]     rem_sh, diff;
    logic [DATA_W-1:0]   rem_step, quo_step;
    logic signed [2*DATA_W-1:0] ext_a, ext_b, prod;

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    always_comb begin
        start_any = bus.op_mult | bus.op_multu | bus.op_div | bus.op_divu;
        accept    = (state_q == IDLE) && start_any && !bus.flush;
        // Priority mult > multu > div > divu decides signedness on multi-hot starts.
        start_sgn = bus.op_mult | (~bus.op_multu & bus.op_div);

        // Borrow out of the 33-bit subtract means the shifted remainder was smaller.
        rem_sh   = {rem_q, quo_q[DATA_W-1]};
        diff     = rem_sh - {1'b0, dvs_q};
        take     = ~diff[DATA_W];
        rem_step = take ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
        quo_step = {quo_q[DATA_W-2:0], take};

        ext_a = {{DATA_W{sgn_q & a_q[DATA_W-1]}}, a_q};
        ext_b = {{DATA_W{sgn_q & b_q[DATA_W-1]}}, b_q};
        prod  = ext_a * ext_b;
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (bus.op_mult | bus.op_multu) ? MUL : DIV;
                    a_d     = bus.src_a;
                    b_d     = bus.src_b;
                    sgn_d   = start_sgn;
                    quo_d   = cond_neg(bus.src_a, start_sgn & bus.src_a[DATA_W-1]);
                    dvs_d   = cond_neg(bus.src_b, start_sgn & bus.src_b[DATA_W-1]);
                    rem_d   = '0;
                    cnt_d   = '0;
                end else if (!bus.flush) begin
                    if (bus.mthi) hi_d = bus.wdata;
                    if (bus.mtlo) lo_d = bus.wdata;
                end
            end
            MUL: begin
                state_d = IDLE;
                if (!bus.flush) {hi_d, lo_d} = prod;
            end
            DIV: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (b_q == '0) begin
                    state_d = IDLE;
                    hi_d    = a_q;
                    lo_d    = '1;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = IDLE;
                        lo_d    = cond_neg(quo_step, sgn_q & (a_q[DATA_W-1] ^ b_q[DATA_W-1]));
                        hi_d    = cond_neg(rem_step, sgn_q & a_q[DATA_W-1]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.stall = busy_q | (start_any & ~bus.flush);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed corner cases plus random operations
// checked against an arithmetic reference model.
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    muldiv_if #(.DATA_W(32)) bus();
    muldiv_ctrl #(.DATA_W(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          stall;
        bit          chk_stall;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    int          run    = 0;
    bit          mt_pend   = 1'b0;
    logic        busy_prev = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // ops = {mult, multu, div, divu}; n = cycles spent outside IDLE
    function automatic void model(input logic [3:0] ops, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] rh, output logic [31:0] rl, output int n);
        longint          sp;
        longint unsigned up;
        int              sa, sbv, q, r;
        sa = a;
        sbv = b;
        rh = '0;
        rl = '0;
        n  = 32;
        if (ops[3]) begin
            sp = longint'(sa) * longint'(sbv);
            rh = sp[63:32];
            rl = sp[31:0];
            n  = 1;
        end else if (ops[2]) begin
            up = {32'h0, a} * {32'h0, b};
            rh = up[63:32];
            rl = up[31:0];
            n  = 1;
        end else if (b == 32'h0) begin
            rh = a;
            rl = 32'hFFFF_FFFF;
            n  = 1;
        end else if (ops[1]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                rl = 32'h8000_0000;
                rh = 32'h0;
            end else begin
                q  = sa / sbv;
                r  = sa % sbv;
                rl = q;
                rh = r;
            end
        end else begin
            rl = a / b;
            rh = a % b;
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (mt_pend) begin
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty_mt: got no entry, required one");
            end else begin
                e = sb.pop_front();
                check("mt_hi", bus.hi, e.hi);
                check("mt_lo", bus.lo, e.lo);
            end
        end
        if (busy_prev && !bus.busy) begin
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty_op: got no entry, required one");
            end else begin
                e = sb.pop_front();
                check("op_hi", bus.hi, e.hi);
                check("op_lo", bus.lo, e.lo);
                if (e.chk_stall) check("stall_len", 32'(run), 32'(e.stall));
            end
            run = 0;
        end
        if (!resetn) run = 0;
        else if (bus.stall) run++;
        mt_pend   = (bus.mthi | bus.mtlo) & ~bus.busy & resetn;
        busy_prev = bus.busy;
    end

    task automatic do_mt(input bit h, input bit l, input logic [31:0] d, input bit fl);
        bus.mthi  = h;
        bus.mtlo  = l;
        bus.wdata = d;
        bus.flush = fl;
        if (!fl) begin
            if (h) m_hi = d;
            if (l) m_lo = d;
        end
        sb.push_back('{m_hi, m_lo, 0, 1'b0});
        @(posedge clk); #1;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.flush = 1'b0;
    endtask

    // abort_cyc: op cycle (1-based) in which flush, or reset if by_rst, is raised
    task automatic do_op(input logic [3:0] ops, input logic [31:0] a, input logic [31:0] b,
                         input int abort_cyc, input bit by_rst, input int mt_cyc, input bit mt_start);
        logic [31:0] rh, rl;
        int          n, cyc;
        model(ops, a, b, rh, rl, n);
        if (mt_start) sb.push_back('{m_hi, m_lo, 0, 1'b0});
        if (abort_cyc >= 1 && abort_cyc <= n) begin
            if (by_rst) begin
                m_hi = '0;
                m_lo = '0;
                sb.push_back('{32'h0, 32'h0, abort_cyc, 1'b1});
            end else begin
                sb.push_back('{m_hi, m_lo, abort_cyc + 1, 1'b1});
            end
        end else begin
            m_hi = rh;
            m_lo = rl;
            sb.push_back('{rh, rl, n + 1, 1'b1});
        end

        {bus.op_mult, bus.op_multu, bus.op_div, bus.op_divu} = ops;
        bus.src_a = a;
        bus.src_b = b;
        if (mt_start) begin
            bus.mthi  = 1'b1;
            bus.wdata = $urandom;
        end
        @(posedge clk); #1;
        {bus.op_mult, bus.op_multu, bus.op_div, bus.op_divu} = 4'b0;
        bus.mthi  = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        cyc = 1;
        while (bus.busy && cyc < 200) begin
            if (cyc == abort_cyc) begin
                if (by_rst) resetn = 1'b0;
                else        bus.flush = 1'b1;
            end
            if (cyc == mt_cyc) begin
                bus.mthi  = 1'b1;
                bus.wdata = 32'hA5A5_A5A5;
            end
            @(posedge clk); #1;
            bus.flush = 1'b0;
            bus.mthi  = 1'b0;
            resetn    = 1'b1;
            cyc++;
        end
        check("op_done_in_bound", 32'(cyc < 200), 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, required finish before 1ms");
        $fatal(1);
    end

    initial begin
        logic [3:0]  ops;
        logic [31:0] ra, rb;
        int          k;
        resetn      = 1'b0;
        bus.op_mult = 1'b0; bus.op_multu = 1'b0; bus.op_div = 1'b0; bus.op_divu = 1'b0;
        bus.src_a   = '0;   bus.src_b    = '0;
        bus.mthi    = 1'b0; bus.mtlo     = 1'b0; bus.wdata  = '0;  bus.flush = 1'b0;

        #2 bus.op_mult = 1'b1;
        #1;
        check("rst_stall", 32'(bus.stall), 32'h1);
        check("rst_busy",  32'(bus.busy),  32'h0);
        check("rst_hi",    bus.hi, 32'h0);
        check("rst_lo",    bus.lo, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        check("rst_no_accept", 32'(bus.busy), 32'h0);
        bus.op_mult = 1'b0;
        resetn      = 1'b1;
        @(posedge clk); #1;

        bus.op_div = 1'b1;
        bus.flush  = 1'b1;
        #1;
        check("flush_start_stall", 32'(bus.stall), 32'h0);
        @(posedge clk); #1;
        bus.op_div = 1'b0;
        bus.flush  = 1'b0;
        check("flush_start_busy", 32'(bus.busy), 32'h0);

        do_op(4'b1000, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 0);
        do_op(4'b0100, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 0);
        do_op(4'b0010, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0);
        do_op(4'b0001, 32'd100, 32'd7, 0, 0, 0, 0);
        do_op(4'b0001, 32'h1234, 32'h0, 0, 0, 0, 0);
        do_op(4'b0010, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
        do_op(4'b0010, 32'h1234_5678, 32'h345, 10, 0, 5, 0);
        do_mt(1'b0, 1'b1, 32'h55, 1'b0);
        do_op(4'b0010, 32'hDEAD_BEEF, 32'h13, 20, 1, 0, 0);
        repeat (40) @(posedge clk);
        #1;
        do_mt(1'b1, 1'b0, 32'h0BAD_0BAD, 1'b1);
        do_op(4'b1010, 32'd7, 32'hFFFF_FFFB, 0, 0, 0, 0);
        do_op(4'b0001, 32'hFFFF_FFFF, 32'd16, 0, 0, 0, 1);
        do_op(4'b1000, 32'd5, 32'd6, 1, 0, 0, 0);
        do_op(4'b0010, 32'd9, 32'h0, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 9);
            if (k < 2) begin
                bit h, l;
                h = 1'($urandom_range(0, 1));
                l = !h | 1'($urandom_range(0, 1));
                do_mt(h, l, $urandom, ($urandom_range(0, 3) == 0));
            end else begin
                if ($urandom_range(0, 9) == 0) ops = 4'($urandom_range(1, 15));
                else                           ops = 4'b0001 << $urandom_range(0, 3);
                ra = $urandom;
                case ($urandom_range(0, 9))
                    0:       rb = 32'h0;
                    1, 2, 3: rb = $urandom_range(1, 20);
                    4:       rb = 32'hFFFF_FFFF;
                    default: rb = $urandom;
                endcase
                do_op(ops, ra, rb,
                      ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 34)) : 0, 1'b0,
                      ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 32)) : 0,
                      ($urandom_range(0, 9) == 0));
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and resetn.
REQ-002 clk  input  1  Rising-edge clock for all state.
REQ-003 resetn  input  1  Asynchronous active-low reset.
REQ-004 op_mult, op_multu, op_div, op_divu  input  1 each  One-hot start pulses from the E-stage decoder, high for one cycle per instruction.
REQ-005 src_a, src_b  input  32 each  Operand values (rs, rt), sampled in the start cycle.
REQ-006 mthi, mtlo  input  1 each  GPR-to-HI and GPR-to-LO write strobes.
REQ-007 wdata  input  32  Data for mthi or mtlo.
REQ-008 flush  input  1  Exception or ERET flush; aborts any operation in progress.
REQ-009 hi, lo  output  32 each  Architectural HI and LO register values, read by MFHI and MFLO.
REQ-010 busy  output  1  Registered; high while the FSM is not in IDLE.
REQ-011 stall  output  1  Combinational pipeline stall request: busy OR (any start pulse AND NOT flush).

Function
REQ-012 The FSM SHALL have three states, IDLE, MUL and DIV, encoded in 2 bits; value 2'b11 is illegal and SHALL return to IDLE.
REQ-013 In IDLE, a start pulse with flush low SHALL latch src_a, src_b, signedness and op type, and SHALL move the FSM to MUL (mult/multu) or DIV (div/divu) on the next edge.
REQ-014 Start pulses SHALL be ignored while busy is high.
REQ-015 More than one start pulse high in the same cycle SHALL be treated as a decoder error; priority SHALL be mult > multu > div > divu.
REQ-016 In MUL, the block SHALL form the 64-bit product (signed for mult, unsigned for multu), write {hi,lo} = product at the end of the cycle, and return to IDLE; stall SHALL be high for exactly 2 cycles (start cycle and MUL cycle).
REQ-017 On entry to DIV, the block SHALL load the magnitudes of the operands (two's-complement absolute value when signed) and clear a 6-bit counter.
REQ-018 DIV SHALL perform one restoring shift-subtract step per cycle for 32 cycles.
REQ-019 After the 32nd step, quotient and remainder SHALL be sign-corrected: quotient negated if signed and src_a[31]^src_b[31]; remainder negated if signed and src_a[31].
REQ-020 At the end of the 32nd DIV cycle, the block SHALL write lo = quotient and hi = remainder, and the FSM SHALL go to IDLE; stall SHALL be high for exactly 33 cycles.
REQ-021 Division by zero SHALL skip the iterations: 1 cycle in DIV, then hi = src_a and lo = 32'hFFFF_FFFF for both div and divu; stall SHALL be high for 2 cycles.
REQ-022 The signed overflow case 0x8000_0000 / 0xFFFF_FFFF SHALL yield lo = 0x8000_0000 and hi = 0.
REQ-023 mthi and mtlo SHALL take effect only in IDLE, writing wdata at the clock edge and visible on the next cycle.
REQ-024 mthi and mtlo SHALL be ignored while busy is high, when flush is high, or in the same cycle as an accepted start pulse (the start takes precedence).
REQ-025 flush high SHALL force the FSM to IDLE on the next edge with no hi/lo write; a start pulse coinciding with flush SHALL NOT be accepted.
REQ-026 hi and lo SHALL change only on a MUL completion, a DIV completion, mthi/mtlo, or reset.

Reset
REQ-027 When resetn is low, the block SHALL set the state to IDLE and clear hi, lo, busy, the counter and all operand/partial registers to 0, regardless of clk.
REQ-028 With resetn low, stall SHALL equal the start-pulse term only, and no start SHALL be accepted.
REQ-029 Reset asserted mid-DIV SHALL abort the operation, with no completion write after resetn is released.

Verification
REQ-030 mult with src_a = 0xFFFF_FFFE (-2), src_b = 3 -> stall high for 2 cycles, then {hi,lo} = 0xFFFF_FFFF_FFFF_FFFA; multu with the same operands -> hi = 0x0000_0002, lo = 0xFFFF_FFFA.
REQ-031 div with src_a = -7 (0xFFFF_FFF9), src_b = 2 -> stall high for 33 cycles, then lo = 0xFFFF_FFFD (-3), hi = 0xFFFF_FFFF (-1); divu with 100, 7 -> lo = 14, hi = 2.
REQ-032 divu with src_b = 0 and src_a = 0x1234 -> 2-cycle stall, then hi = 0x1234, lo = 0xFFFF_FFFF; div with 0x8000_0000 / 0xFFFF_FFFF -> lo = 0x8000_0000, hi = 0.
REQ-033 Start div, assert flush in DIV cycle 10 -> busy low the next cycle and hi/lo unchanged; mthi 0xA5A5_A5A5 issued while busy -> hi unchanged.
REQ-034 mtlo 0x0000_0055 in IDLE -> lo = 0x55 on the next cycle; resetn pulsed low in DIV cycle 20 -> hi = lo = 0, busy = 0 immediately, and no later write.
